// File: rtl/slow_timer_pkg.sv
// Shared types and constants for the slow-mode timer: FSM states, SlowSrc codes, default tick divider.
package slow_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam int DEF_TICK_DIV = 256;

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_IACK = 3'd1;
    localparam logic [2:0] SRC_VIA  = 3'd2;
    localparam logic [2:0] SRC_IWM  = 3'd3;
    localparam logic [2:0] SRC_SCC  = 3'd4;
    localparam logic [2:0] SRC_SCSI = 3'd5;
    localparam logic [2:0] SRC_SND  = 3'd6;

    // hits[0]=IACK ... hits[5]=Snd; lowest index wins.
    function automatic logic [2:0] src_encode(input logic [5:0] hits);
        logic [2:0] code;
        code = SRC_NONE;
        if      (hits[0]) code = SRC_IACK;
        else if (hits[1]) code = SRC_VIA;
        else if (hits[2]) code = SRC_IWM;
        else if (hits[3]) code = SRC_SCC;
        else if (hits[4]) code = SRC_SCSI;
        else if (hits[5]) code = SRC_SND;
        return code;
    endfunction

endpackage

// File: rtl/slow_prescaler.sv
// Hold-tick prescaler: counts 0..TICK_DIV-1 while enabled, clear has priority.
module slow_prescaler
    import slow_timer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PRE_W    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // Terminal-count flag only; the FSM qualifies it with its own enable to avoid a comb loop.
    assign tick_o = (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (clr_i) begin
            pre_d = '0;
        end else if (en_i) begin
            if (pre_q == LAST) pre_d = '0;
            else               pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pre_q <= '0;
        else       pre_q <= pre_d;
    end

endmodule

// File: rtl/slow_timer.sv
// Slow-mode request timer: holds Slow for a bus access to an enabled slow device plus a tick-based hold.
// Optional SLOW_SOURCE_LATCH_EN adds SlowSrc, the highest-priority source of the last trigger.
//
// state  | meaning
// IDLE   | no slow request; waiting for a triggering access
// ACCESS | slow access in progress while BACT is high
// HOLD   | post-access hold, cnt ticks of TICK_DIV clocks remaining
module slow_timer
    import slow_timer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PRE_W    = 8
) (
    input  logic       CLK,
    input  logic       POR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCSWR,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       Slow,
    output logic       ClockGate
`ifdef SLOW_SOURCE_LATCH_EN
    ,
    output logic [2:0] SlowSrc
`endif
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       bactr_q;
    logic       slow_q;
    logic       cg_q;
    logic [5:0] hits;
    logic       hit;
    logic       trig;
    logic       pre_clr;
    logic       pre_en;
    logic       pre_last;

    assign hits = {SndCSWR & SlowSnd, SCSICS & SlowSCSI, SCCCS & SlowSCC,
                   IWMCS & SlowIWM, VIACS & SlowVIA, IACKCS & SlowIACK};
    assign hit  = |hits;
    assign trig = BACT & ~bactr_q & hit;

    slow_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PRE_W    (PRE_W)
    ) u_pre (
        .clk_i  (CLK),
        .rst_i  (POR),
        .clr_i  (pre_clr),
        .en_i   (pre_en),
        .tick_o (pre_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_clr = 1'b0;
        pre_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!BACT) begin
                    if (SlowTimeout == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = SlowTimeout;
                        pre_clr = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // A retrigger freezes cnt and prescaler; both reload at the next ACCESS exit.
                if (trig) begin
                    state_d = ST_ACCESS;
                end else begin
                    pre_en = 1'b1;
                    if (pre_last) begin
                        if (cnt_q == 4'd1) state_d = ST_IDLE;
                        else               cnt_d   = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (POR) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            bactr_q <= 1'b0;
            slow_q  <= 1'b0;
            cg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bactr_q <= BACT;
            slow_q  <= (state_d != ST_IDLE);
            cg_q    <= (state_d != ST_IDLE) & SlowClockGate;
        end
    end

    assign Slow      = slow_q;
    assign ClockGate = cg_q;

`ifdef SLOW_SOURCE_LATCH_EN
    logic [2:0] src_q;

    always_ff @(posedge CLK) begin
        if (POR)       src_q <= SRC_NONE;
        else if (trig) src_q <= src_encode(hits);
    end

    assign SlowSrc = src_q;
`endif

endmodule

// File: tb/tb_slow_timer.sv
// Directed self-checking bench for slow_timer with the default TICK_DIV of 256.
module tb_slow_timer;

    logic       CLK = 1'b0;
    logic       POR = 1'b1;
    logic       BACT = 1'b0;
    logic       IACKCS = 1'b0, VIACS = 1'b0, IWMCS = 1'b0, SCCCS = 1'b0, SCSICS = 1'b0, SndCSWR = 1'b0;
    logic       SlowIACK = 1'b0, SlowVIA = 1'b0, SlowIWM = 1'b0, SlowSCC = 1'b0, SlowSCSI = 1'b0, SlowSnd = 1'b0;
    logic       SlowClockGate = 1'b0;
    logic [3:0] SlowTimeout = 4'd0;
    logic       Slow;
    logic       ClockGate;
`ifdef SLOW_SOURCE_LATCH_EN
    logic [2:0] SlowSrc;
`endif

    int checks = 0;
    int errors = 0;

    slow_timer dut (
        .CLK           (CLK),
        .POR           (POR),
        .BACT          (BACT),
        .IACKCS        (IACKCS),
        .VIACS         (VIACS),
        .IWMCS         (IWMCS),
        .SCCCS         (SCCCS),
        .SCSICS        (SCSICS),
        .SndCSWR       (SndCSWR),
        .SlowIACK      (SlowIACK),
        .SlowVIA       (SlowVIA),
        .SlowIWM       (SlowIWM),
        .SlowSCC       (SlowSCC),
        .SlowSCSI      (SlowSCSI),
        .SlowSnd       (SlowSnd),
        .SlowClockGate (SlowClockGate),
        .SlowTimeout   (SlowTimeout),
        .Slow          (Slow),
        .ClockGate     (ClockGate)
`ifdef SLOW_SOURCE_LATCH_EN
        ,
        .SlowSrc       (SlowSrc)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Steps until Slow is low, bounded by max; n is the number of edges taken.
    task automatic run_until_low(input int max, output int n);
        n = 0;
        while (Slow !== 1'b0 && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic count_high(input int cycles, output int hi);
        hi = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (Slow !== 1'b0) hi++;
        end
    endtask

    task automatic test_reset();
        int hi;
        POR = 1'b1;
        step();
        step();
        checks++; if (Slow !== 1'b0) begin errors++; $display("FAIL reset_slow got %b exp 0", Slow); end
        checks++; if (ClockGate !== 1'b0) begin errors++; $display("FAIL reset_cg got %b exp 0", ClockGate); end
        POR = 1'b0;
        step();
        SlowVIA = 1'b1; VIACS = 1'b1; SlowClockGate = 1'b1; SlowTimeout = 4'd1;
        BACT = 1'b1;
        step();
        step();
        BACT = 1'b0;
        step();
        repeat (10) step();
        checks++; if (Slow !== 1'b1) begin errors++; $display("FAIL prepor_slow got %b exp 1", Slow); end
        checks++; if (ClockGate !== 1'b1) begin errors++; $display("FAIL prepor_cg got %b exp 1", ClockGate); end
        POR = 1'b1;
        step();
        checks++; if (Slow !== 1'b0) begin errors++; $display("FAIL por_hold_slow got %b exp 0", Slow); end
        checks++; if (ClockGate !== 1'b0) begin errors++; $display("FAIL por_hold_cg got %b exp 0", ClockGate); end
        POR = 1'b0;
        count_high(300, hi);
        checks++; if (hi !== 0) begin errors++; $display("FAIL por_pending high_cycles got %0d exp 0", hi); end
        SlowVIA = 1'b0; VIACS = 1'b0; SlowClockGate = 1'b0;
    endtask

    task automatic test_basic_hold();
        int n;
        SlowVIA = 1'b1; VIACS = 1'b1; SlowTimeout = 4'd3;
        checks++; if (Slow !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", Slow); end
        BACT = 1'b1;
        step();
        checks++; if (Slow !== 1'b1) begin errors++; $display("FAIL basic_rise got %b exp 1", Slow); end
        step();
        SlowVIA = 1'b0;
        step();
        step();
        BACT = 1'b0;
        run_until_low(2000, n);
        checks++; if (n !== 769) begin errors++; $display("FAIL basic_hold_len got %0d exp 769", n); end
        VIACS = 1'b0;
    endtask

    task automatic test_zero_timeout();
        int n, hi;
        SlowSCC = 1'b1; SCCCS = 1'b1; SlowTimeout = 4'd0;
        BACT = 1'b1;
        step();
        checks++; if (Slow !== 1'b1) begin errors++; $display("FAIL zero_rise got %b exp 1", Slow); end
        repeat (4) step();
        BACT = 1'b0;
        run_until_low(50, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL zero_fall got %0d exp 1", n); end
        count_high(600, hi);
        checks++; if (hi !== 0) begin errors++; $display("FAIL zero_no_hold got %0d exp 0", hi); end
        SlowSCC = 1'b0; SCCCS = 1'b0;
    endtask

    task automatic test_disabled_source();
        int n, hi, hi2;
        SlowIWM = 1'b0; IWMCS = 1'b1; SlowTimeout = 4'hF;
        BACT = 1'b1;
        count_high(3, hi);
        BACT = 1'b0;
        count_high(5, hi2);
        checks++; if (hi + hi2 !== 0) begin errors++; $display("FAIL disabled_iwm got %0d exp 0", hi + hi2); end
        IWMCS = 1'b0;
        SlowSCSI = 1'b1; SCSICS = 1'b1; SlowTimeout = 4'd1;
        BACT = 1'b1;
        step();
        checks++; if (Slow !== 1'b1) begin errors++; $display("FAIL scsi_rise got %b exp 1", Slow); end
        step();
        BACT = 1'b0;
        run_until_low(600, n);
        checks++; if (n !== 257) begin errors++; $display("FAIL scsi_hold_len got %0d exp 257", n); end
        SlowSCSI = 1'b0; SCSICS = 1'b0;
    endtask

    task automatic test_late_select();
        int hi, hi2;
        SlowSCC = 1'b1; SCCCS = 1'b0;
        BACT = 1'b1;
        step();
        SCCCS = 1'b1;
        count_high(4, hi);
        BACT = 1'b0;
        count_high(3, hi2);
        checks++; if (hi + hi2 !== 0) begin errors++; $display("FAIL late_select got %0d exp 0", hi + hi2); end
        SlowSCC = 1'b0; SCCCS = 1'b0;
    endtask

    task automatic test_retrigger();
        int n, gap;
        SlowVIA = 1'b1; VIACS = 1'b1; SlowTimeout = 4'd2;
        gap = 0;
        BACT = 1'b1;
        repeat (3) step();
        BACT = 1'b0;
        repeat (257) begin
            step();
            if (Slow !== 1'b1) gap++;
        end
        BACT = 1'b1;
        step();
        if (Slow !== 1'b1) gap++;
        SlowTimeout = 4'd1;
        repeat (2) begin
            step();
            if (Slow !== 1'b1) gap++;
        end
        BACT = 1'b0;
        step();
        if (Slow !== 1'b1) gap++;
        SlowTimeout = 4'hF;
        run_until_low(1000, n);
        checks++; if (gap !== 0) begin errors++; $display("FAIL retrig_gap got %0d exp 0", gap); end
        checks++; if (n !== 256) begin errors++; $display("FAIL retrig_hold_len got %0d exp 256", n); end
        SlowVIA = 1'b0; VIACS = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, gap;
        SlowVIA = 1'b1; VIACS = 1'b1; SlowTimeout = 4'd1;
        gap = 0;
        BACT = 1'b1;
        step();
        step();
        BACT = 1'b0;
        repeat (256) begin
            step();
            if (Slow !== 1'b1) gap++;
        end
        BACT = 1'b1;
        step();
        checks++; if (Slow !== 1'b1) begin errors++; $display("FAIL b2b_trig_slow got %b exp 1", Slow); end
        step();
        BACT = 1'b0;
        run_until_low(600, n);
        checks++; if (gap !== 0) begin errors++; $display("FAIL b2b_gap got %0d exp 0", gap); end
        checks++; if (n !== 257) begin errors++; $display("FAIL b2b_hold_len got %0d exp 257", n); end
        SlowVIA = 1'b0; VIACS = 1'b0;
    endtask

    task automatic test_clock_gate();
        int n;
        SlowClockGate = 1'b1; SlowVIA = 1'b1; VIACS = 1'b1; SlowTimeout = 4'd2;
        SlowSCC = 1'b1; SCCCS = 1'b1;
        BACT = 1'b1;
        step();
`ifdef SLOW_SOURCE_LATCH_EN
        checks++; if (SlowSrc !== 3'd2) begin errors++; $display("FAIL src_prio got %0d exp 2", SlowSrc); end
`endif
        step();
        BACT = 1'b0;
        step();
        checks++; if (Slow !== 1'b1) begin errors++; $display("FAIL cg_hold_slow got %b exp 1", Slow); end
        checks++; if (ClockGate !== 1'b1) begin errors++; $display("FAIL cg_hold got %b exp 1", ClockGate); end
        SlowClockGate = 1'b0;
        checks++; if (ClockGate !== 1'b1) begin errors++; $display("FAIL cg_latency got %b exp 1", ClockGate); end
        step();
        checks++; if (ClockGate !== 1'b0) begin errors++; $display("FAIL cg_off got %b exp 0", ClockGate); end
        checks++; if (Slow !== 1'b1) begin errors++; $display("FAIL cg_off_slow got %b exp 1", Slow); end
        SlowClockGate = 1'b1;
        step();
        checks++; if (ClockGate !== 1'b1) begin errors++; $display("FAIL cg_on got %b exp 1", ClockGate); end
        run_until_low(1000, n);
        checks++; if (n !== 510) begin errors++; $display("FAIL cg_hold_len got %0d exp 510", n); end
        checks++; if (ClockGate !== 1'b0) begin errors++; $display("FAIL cg_idle got %b exp 0", ClockGate); end
`ifdef SLOW_SOURCE_LATCH_EN
        checks++; if (SlowSrc !== 3'd2) begin errors++; $display("FAIL src_hold got %0d exp 2", SlowSrc); end
`endif
        SlowClockGate = 1'b0; SlowVIA = 1'b0; VIACS = 1'b0; SlowSCC = 1'b0; SCCCS = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_hold();
        test_zero_timeout();
        test_disabled_source();
        test_late_select();
        test_retrigger();
        test_back_to_back();
        test_clock_gate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slow_timer.md
Name: slow_timer

Overview:
- Consumes the slow-mode configuration register (per-device Slow* enables, SlowClockGate, SlowTimeout[3:0]).
- Decides when the accelerated CPU must drop to stock speed for a peripheral access.
- On a bus access to an enabled slow device, asserts Slow for the whole access plus a programmable hold window of SlowTimeout × TICK_DIV clocks.
- Downstream clock/speed logic uses Slow and ClockGate.

Parameters:
- TICK_DIV, 256, CLK cycles per hold tick; legal range 2..256.
- PRE_W, 8, prescaler width; must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- POR  in  1  reset, synchronous, active-high.
- BACT  in  1  bus cycle active; chip selects valid while high.
- IACKCS  in  1  interrupt-acknowledge cycle decode.
- VIACS  in  1  VIA select.
- IWMCS  in  1  IWM select.
- SCCCS  in  1  SCC select.
- SCSICS  in  1  SCSI select.
- SndCSWR  in  1  sound/PWM buffer write select.
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd  in  1 each  per-source slow enables.
- SlowClockGate  in  1  permit clock gating while slow.
- SlowTimeout  in  4  hold length in ticks; 0 means no hold.
- Slow  out  1  CPU must run at stock speed.
- ClockGate  out  1  Slow AND SlowClockGate (registered).

Behaviour:
- Single clock CLK. POR is synchronous, active-high, and overrides everything.
- Reset state: IDLE; Slow=0; ClockGate=0; hold counter=0; prescaler=0; BACTr=0.
- BACTr is the one-cycle delayed BACT.
- Hit = (IACKCS&SlowIACK) | (VIACS&SlowVIA) | (IWMCS&SlowIWM) | (SCCCS&SlowSCC) | (SCSICS&SlowSCSI) | (SndCSWR&SlowSnd).
- Trig = BACT & !BACTr & Hit. Evaluated only on the first BACT cycle; selects changing later in the same access are ignored.
- FSM states:
  - IDLE: Trig -> ACCESS.
  - ACCESS: stays while BACT=1. On the BACT=0 cycle: SlowTimeout==0 -> IDLE; otherwise load cnt=SlowTimeout, clear prescaler, go to HOLD.
  - HOLD: prescaler increments each cycle; tick when prescaler==TICK_DIV-1, then wraps to 0.
    - On tick: cnt==1 -> IDLE, else cnt--.
    - Trig -> ACCESS; counter and prescaler are frozen and reloaded at the next ACCESS exit. Trig has priority over a same-cycle tick.
- Outputs are registered and derive from the next state:
  - Slow = (next state != IDLE). Slow rises the cycle after Trig (latency 1) and falls the cycle after the final tick or after an ACCESS exit with SlowTimeout==0.
  - ClockGate = next Slow & SlowClockGate. It tracks live changes of SlowClockGate with 1-cycle latency.
- Total hold after BACT falls = SlowTimeout × TICK_DIV cycles exactly (+1 output latency).
- Boundary cases:
  - SlowTimeout is sampled only at ACCESS exit; changes during HOLD do not alter the running count.
  - An enable cleared mid-access does not end the current ACCESS or HOLD.
  - BACT high continuously never re-triggers; a new rising edge is required.
  - A back-to-back access whose BACT rises in the cycle the hold expires is treated as a Trig from IDLE-equivalent: ACCESS is entered and Slow stays high without a gap.
  - POR mid-HOLD or mid-ACCESS returns immediately to the reset state.
- Prescaler and counter never wrap below 0; cnt==0 is unreachable in HOLD.

Optional Feature:
- Macro: SLOW_SOURCE_LATCH_EN.
- Defined: adds output SlowSrc[2:0], loaded on every Trig with the highest-priority hitting source. Encoding: 1=IACK, 2=VIA, 3=IWM, 4=SCC, 5=SCSI, 6=Snd, in that priority order. Reset 0. Holds its value after return to IDLE.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ACCESS, HOLD), 2-bit;
  - SlowSrc encoding constants;
  - default TICK_DIV.
- One sub-module, slow_prescaler: counter with clear and enable, emitting a one-cycle tick at TICK_DIV-1. The FSM, Hit/Trig decode and outputs stay in slow_timer.

Test Plan:
- Reset: assert POR mid-HOLD, then release. Required: Slow=0, ClockGate=0, and no tick-driven exit is pending.
- Basic hold: SlowVIA=1, SlowTimeout=3, TICK_DIV=256; VIACS with a 4-cycle BACT. Required: Slow high from cycle 1 after BACT rise until 768 cycles after BACT fall (+1).
- Zero timeout: SlowSCC=1, SlowTimeout=0, 5-cycle SCC access. Required: Slow high exactly 5 cycles, offset by 1; never enters HOLD.
- Disabled source: SlowIWM=0, IWMCS access with SlowTimeout=F. Required: Slow stays 0. Then a SCSICS access with SlowSCSI=1 triggers normally.
- Retrigger: during HOLD (SlowTimeout=2), a new VIACS access at tick 1, then SlowTimeout changed to 1 before that access ends. Required: hold restarts from BACT fall at 1×TICK_DIV cycles; Slow shows no low gap.
- ClockGate and priority: SlowClockGate toggled 1→0 mid-HOLD. Required: ClockGate follows one cycle later while Slow stays high. With SLOW_SOURCE_LATCH_EN, simultaneous VIACS+SCCCS hit gives SlowSrc=2.
